// File: rtl/seg_display_ctrl.sv
// Memory-mapped 8-digit seven-segment controller: hex window shows the raw word,
// decimal window runs a 32-step double-dabble conversion before committing.
module seg_display_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ioWrite,
  input  logic        SEGCtrl16,
  input  logic        SEGCtrl10,
  input  logic [31:0] write_data,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out,
  output logic        busy
);

  // state  | meaning
  // S_IDLE | no conversion running, display holds committed content
  // S_CONV | double-dabble in progress, one shift per cycle for 32 cycles
  typedef enum logic {S_IDLE, S_CONV} state_t;
  typedef enum logic [1:0] {M_HEX, M_DEC, M_OVF} mode_t;

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  state_t      state, state_nxt;
  mode_t       mode, mode_nxt;
  logic [31:0] disp, disp_nxt, shf, shf_nxt;
  logic [39:0] bcd, bcd_nxt, bcd_adj;
  logic [71:0] shifted;
  logic [4:0]  cnt, cnt_nxt;
  logic        hex_wr, dec_wr;

  logic [PW-1:0] pre, pre_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [3:0]    nib;
  logic [31:0]   upper;
  logic [7:0]    glyph, render;

  assign hex_wr = ioWrite & SEGCtrl16;
  assign dec_wr = ioWrite & SEGCtrl10 & ~SEGCtrl16;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, shf} << 1;

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    disp_nxt  = disp;
    shf_nxt   = shf;
    bcd_nxt   = bcd;
    cnt_nxt   = cnt;
    if (hex_wr) begin
      state_nxt = S_IDLE;
      disp_nxt  = write_data;
      mode_nxt  = M_HEX;
    end else if (dec_wr) begin
      state_nxt = S_CONV;
      shf_nxt   = write_data;
      bcd_nxt   = '0;
      cnt_nxt   = '0;
    end else if (state == S_CONV) begin
      {bcd_nxt, shf_nxt} = shifted;
      cnt_nxt = cnt + 5'd1;
      // last shift: commit straight from the freshly shifted accumulator
      if (cnt == 5'd31) begin
        state_nxt = S_IDLE;
        if (bcd_nxt[39:32] != 8'h00) begin
          mode_nxt = M_OVF;
        end else begin
          mode_nxt = M_DEC;
          disp_nxt = bcd_nxt[31:0];
        end
      end
    end
  end

  assign pre_nxt = (pre == PRE_MAX) ? '0 : pre + 1'b1;
  assign idx_nxt = (pre == PRE_MAX) ? idx + 3'd1 : idx;

  // render for the index the outputs will show after this edge
  always_comb begin
    nib   = disp[{idx_nxt, 2'b00} +: 4];
    upper = disp >> {idx_nxt, 2'b00};
    case (nib)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
    case (mode)
      M_DEC:   render = (idx_nxt != 3'd0 && upper == 32'd0) ? 8'hFF : glyph;
      M_OVF:   render = 8'hBF;
      default: render = glyph;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode    <= M_HEX;
      disp    <= '0;
      shf     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      pre     <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      seg_en  <= 8'hFE;
      seg_out <= 8'hC0;
    end else begin
      state   <= state_nxt;
      mode    <= mode_nxt;
      disp    <= disp_nxt;
      shf     <= shf_nxt;
      bcd     <= bcd_nxt;
      cnt     <= cnt_nxt;
      pre     <= pre_nxt;
      idx     <= idx_nxt;
      busy    <= (state_nxt == S_CONV);
      seg_en  <= ~(8'h01 << idx_nxt);
      seg_out <= render;
    end
  end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Memory-mapped 8-digit seven-segment display controller that sits directly downstream of the memory/IO address decoder. It consumes the decoder's `ioWrite`, `SEGCtrl16`, `SEGCtrl10` and `write_data` outputs. A write to the hex window (0xFFFF_F830) shows the 32-bit word as eight hex digits. A write to the decimal window (0xFFFF_F840) converts the unsigned word to BCD with a sequential double-dabble engine and shows it in decimal. The block time-multiplexes the digits onto the board's common segment bus.

## Interface
- `SCAN_DIV`, default 50000, clock cycles each digit stays enabled (must be ≥ 2).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ioWrite`  in  1  IO write strobe from the controller.
- `SEGCtrl16`  in  1  hex display chip select from the decoder.
- `SEGCtrl10`  in  1  decimal display chip select from the decoder.
- `write_data`  in  32  store data from the decoder.
- `seg_en`  out  8  digit enables, active-low; bit 0 is the rightmost digit.
- `seg_out`  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always 1 (off).
- `busy`  out  1  high while a decimal conversion is in progress.

## Operation
- **Write capture**
  - A hex write is sampled when `ioWrite & SEGCtrl16` is high at a rising edge.
  - A decimal write is sampled when `ioWrite & SEGCtrl10` is high at a rising edge.
  - If both are high, the hex write wins and the decimal request is ignored.
- **Hex write**
  - Copies `write_data` into the display nibble register.
  - Sets mode = HEX.
  - Aborts any running conversion; `busy` goes to 0.
- **Decimal write**
  - Loads `write_data` into the conversion shifter.
  - Clears a 40-bit BCD accumulator.
  - Enters CONV with iteration count 0 and `busy` = 1.
  - The display keeps its old content until the conversion commits.
- **Conversion FSM**, states IDLE and CONV:
  - In CONV, each cycle: add 3 to every BCD nibble ≥ 5, then shift {BCD, shifter} left by 1.
  - After the 32nd shift, the FSM commits the result and returns to IDLE.
  - Commit: if BCD digits 9–8 (the top two nibbles) are nonzero, the display shows eight dashes (overflow). Otherwise it shows the low 8 BCD digits, with mode = DEC.
  - A new decimal write while in CONV restarts the conversion from the new value at count 0.
- **Digit rendering**
  - HEX mode: all eight digits use the 0–F glyphs, with no blanking.
  - DEC mode: leading zeros are blanked (0xFF); digit 0 is never blanked.
  - Overflow: every digit shows a dash (0xBF).
- **Glyphs**: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- **Scanning**
  - The prescaler counts 0..SCAN_DIV-1.
  - When it wraps, the digit index advances 0→7, then wraps back to 0.
  - `seg_en` has exactly one bit low: bit[index].
  - `seg_out` shows the glyph for digit[index] of the current display content.
- **Reset values**
  - Display value 0, mode HEX, FSM IDLE, `busy` = 0, prescaler 0, index 0.
  - `seg_en` = 8'hFE, `seg_out` = 8'hC0.

## Timing
- `seg_en`, `seg_out` and `busy` are all registered.
- **Hex write** sampled at edge N: the new glyph for the currently enabled digit appears at `seg_out` after edge N+1. One cycle of display register plus one of output register.
- **Decimal write** sampled at edge N:
  - `busy` = 1 after edge N.
  - Shifts occur on edges N+1..N+32.
  - The commit happens on edge N+32, and `busy` = 0 after edge N+32, so `busy` is high for exactly 32 cycles.
  - Rendered output updates after edge N+33.
- **Digit timing**: each digit is enabled for exactly SCAN_DIV cycles, so a full frame takes 8·SCAN_DIV cycles. The index and `seg_en` change on the same edge as `seg_out`, so no cycle shows a mismatched glyph.
- **Writes without ioWrite**: `SEGCtrl16` or `SEGCtrl10` high while `ioWrite` = 0 has no effect.
- **Reset asserted mid-conversion**: all state returns to reset values immediately (asynchronously). The conversion is discarded.
- **Hex write on the commit edge** (N+32): the hex write wins, and the pending decimal result is dropped.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-scan with SCAN_DIV=4 → `seg_en` = FE, `seg_out` = C0, `busy` = 0 immediately. After release, `seg_en` goes FE, FD, FB … 7F, then wraps to FE, every 4 cycles.
- **Hex write:** hex write 0x1234ABCD → digits 0..7 show 8E? no — digits 0..7 show glyphs for D, C, B, A, 4, 3, 2, 1 = A1, C6, 83, 88, 99, B0, A4, F9. Visible 2 edges after the write.
- **Decimal write with blanking:** decimal write 1234 → `busy` high exactly 32 cycles. Then digits 0..3 = 99, B0, A4, F9 and digits 4..7 = FF. Decimal write 0 → digit 0 = C0, all others FF.
- **Overflow:** decimal write 100000000 → all digits BF. Decimal write 99999999 → all digits 90.
- **Restart:** decimal write 5, then decimal write 42 at cycle +10 → `busy` stays high until 32 cycles after the second write. The display shows 42, never 5.
- **Abort and priority:** decimal write 7, then hex write 0xF at cycle +5 → `busy` falls after the hex write, and the display shows 8E followed by seven C0. Both chip selects high with `ioWrite` → treated as a hex write.
